// File: rtl/button_step_conditioner_pkg.sv
// Shared types and defaults for the push-button step conditioner.
// Repeat FSM encoding, default timing and counter-width helper.
package button_step_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    REPEAT = 2'b10
  } rpt_state_t;

  localparam int DEF_DEBOUNCE   = 4;
  localparam int DEF_HOLD       = 20;
  localparam int DEF_REPEAT     = 8;
  localparam int DEF_REPEAT_EN  = 1;
  localparam int DEF_ACTIVE_LOW = 1;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_step_conditioner_channel.sv
// One button channel: sync, debounce, edge detect, repeat FSM.
// Produces a one-cycle request per press plus repeat, and the held level.
module button_step_conditioner_channel
  import button_step_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int HOLD_CYCLES     = DEF_HOLD,
  parameter int REPEAT_CYCLES   = DEF_REPEAT,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int BTN_ACTIVE_LOW  = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic req,
  output logic held
);

  localparam int RMAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ?
    HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(RMAX);

  localparam logic IDLE_LVL = (BTN_ACTIVE_LOW != 0);
  localparam logic RPT      = (REPEAT_EN != 0);

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_LAST =
    RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST =
    RW'(REPEAT_CYCLES - 1);

  logic [1:0]    sync;
  logic          pressed;
  logic [DW-1:0] cnt;
  logic          stable;
  logic          stable_q;
  logic          rise;

  rpt_state_t    state, state_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          fresh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {2{IDLE_LVL}};
    end else begin
      sync <= {sync[0], btn};
    end
  end

  assign pressed = sync[1] ^ IDLE_LVL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable;
      if (pressed == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable <= pressed;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_q;
  assign held = stable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rcnt  <= '0;
      fresh <= 1'b0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
      fresh <= req;
    end
  end

  // The pulse cycle is not counted, so pulses
  // are always separated by at least one idle cycle.
  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    req     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          req     = 1'b1;
          state_n = HOLD;
          rcnt_n  = '0;
        end
      end
      HOLD: begin
        if (!stable) begin
          state_n = IDLE;
          rcnt_n  = '0;
        end else if (!fresh && RPT) begin
          if (rcnt == HOLD_LAST) begin
            req     = 1'b1;
            state_n = REPEAT;
            rcnt_n  = '0;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!stable) begin
          state_n = IDLE;
          rcnt_n  = '0;
        end else if (!fresh) begin
          if (rcnt == REP_LAST) begin
            req    = 1'b1;
            rcnt_n = '0;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        rcnt_n  = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_step_conditioner.sv
// Two-channel button front end for the up/down display counter.
// Collisions between same-cycle inc/dec requests drop both pulses.
module button_step_conditioner
  import button_step_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int HOLD_CYCLES     = DEF_HOLD,
  parameter int REPEAT_CYCLES   = DEF_REPEAT,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int BTN_ACTIVE_LOW  = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc,
  input  logic btn_dec,
  output logic inc,
  output logic dec,
  output logic inc_held,
  output logic dec_held
);

  logic inc_req;
  logic dec_req;

  button_step_conditioner_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_inc (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_inc),
    .req  (inc_req),
    .held (inc_held)
  );

  button_step_conditioner_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_dec (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_dec),
    .req  (dec_req),
    .held (dec_held)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc <= 1'b0;
      dec <= 1'b0;
    end else begin
      inc <= inc_req & ~dec_req;
      dec <= dec_req & ~inc_req;
    end
  end

endmodule

// File: tb/tb_button_step_conditioner.sv
// Directed bench for button_step_conditioner.
// Pulse edge numbers are logged and compared to hand-derived times.
module tb_button_step_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic btn_inc;
  logic btn_dec;
  logic inc;
  logic dec;
  logic inc_held;
  logic dec_held;

  int n_run  = 0;
  int n_fail = 0;
  int ne     = 0;
  int inc_t[$];
  int dec_t[$];
  logic inc_p = 1'b0;
  logic dec_p = 1'b0;

  button_step_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8),
    .REPEAT_EN       (1),
    .BTN_ACTIVE_LOW  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .inc      (inc),
    .dec      (dec),
    .inc_held (inc_held),
    .dec_held (dec_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ne <= ne + 1;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Per-cycle invariants and pulse logging
  always @(negedge clk) begin
    chk("excl", int'(inc & dec), 0);
    chk("wide", int'((inc & inc_p) | (dec & dec_p)), 0);
    if (inc) inc_t.push_back(ne);
    if (dec) dec_t.push_back(ne);
    inc_p <= inc;
    dec_p <= dec;
  end

  task automatic wait_to(input int n);
    while (ne < n) @(negedge clk);
  endtask

  task automatic clr();
    inc_t.delete();
    dec_t.delete();
  endtask

  int t;
  int r;
  int w3[8]   = '{2, 1, 3, 2, 1, 3, 2, 1};
  int off4[6] = '{0, 21, 30, 39, 48, 57};
  int off6[3] = '{7, 28, 37};

  initial begin
    rst     = 1'b0;
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_inc", int'(inc), 0);
    chk("rst_dec", int'(dec), 0);
    chk("rst_ih", int'(inc_held), 0);
    chk("rst_dh", int'(dec_held), 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_ni", inc_t.size(), 0);
    chk("idle_nd", dec_t.size(), 0);

    // clean press
    clr();
    t = ne;
    btn_inc = 1'b0;
    wait_to(t + 8);
    chk("t2_held", int'(inc_held), 1);
    wait_to(t + 10);
    btn_inc = 1'b1;
    wait_to(t + 26);
    chk("t2_ni", inc_t.size(), 1);
    chk("t2_t", inc_t.size() > 0 ? inc_t[0] : -1, t + 7);
    chk("t2_nd", dec_t.size(), 0);
    chk("t2_rel", int'(inc_held), 0);

    // bouncing dec
    clr();
    for (int i = 0; i < 8; i++) begin
      btn_dec = (i % 2 == 1);
      repeat (w3[i]) @(negedge clk);
    end
    t = ne;
    btn_dec = 1'b0;
    wait_to(t + 12);
    chk("t3_held", int'(dec_held), 1);
    btn_dec = 1'b1;
    wait_to(t + 30);
    chk("t3_nd", dec_t.size(), 1);
    chk("t3_t", dec_t.size() > 0 ? dec_t[0] : -1, t + 7);
    chk("t3_ni", inc_t.size(), 0);

    // auto-repeat
    clr();
    t = ne;
    btn_inc = 1'b0;
    wait_to(t + 60);
    btn_inc = 1'b1;
    wait_to(t + 85);
    chk("t4_n", inc_t.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_p%0d", i),
          i < inc_t.size() ? inc_t[i] : -1,
          t + 7 + off4[i]);
    end
    chk("t4_nd", dec_t.size(), 0);

    // simultaneous press
    clr();
    t = ne;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    wait_to(t + 8);
    chk("t5_ih", int'(inc_held), 1);
    chk("t5_dh", int'(dec_held), 1);
    wait_to(t + 12);
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    wait_to(t + 30);
    chk("t5_ni", inc_t.size(), 0);
    chk("t5_nd", dec_t.size(), 0);

    // reset mid-repeat with button held
    clr();
    t = ne;
    btn_inc = 1'b0;
    wait_to(t + 32);
    chk("t6_pre", inc_t.size(), 2);
    rst = 1'b0;
    #1;
    chk("t6_r_inc", int'(inc), 0);
    chk("t6_r_ih", int'(inc_held), 0);
    repeat (2) @(negedge clk);
    chk("t6_r2_inc", int'(inc), 0);
    chk("t6_r2_ih", int'(inc_held), 0);
    clr();
    r = ne;
    rst = 1'b1;
    wait_to(r + 38);
    btn_inc = 1'b1;
    wait_to(r + 60);
    chk("t6_n", inc_t.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_p%0d", i),
          i < inc_t.size() ? inc_t[i] : -1,
          r + off6[i]);
    end
    chk("t6_nd", dec_t.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
